// File: rtl/stage_scheduler_if.sv
// Step/config/control bundle between the stage scheduler and its datapath/controller.
interface stage_scheduler_if #(
  parameter int NA = 8,
  parameter int NC = 4,
  parameter int ND = 16
);
  // control
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  // table programming and run bounds
  logic          cfg_we;
  logic [NC-1:0] cfg_addr;
  logic [NA-1:0] cfg_data;
  logic [NC-1:0] last_stage_idx;
  logic [ND-1:0] stop_epoch;
  // step handshake
  logic          step_valid;
  logic          step_ready;
  logic [NA-1:0] count_step;
  logic [NC-1:0] count_stage;
  logic [ND-1:0] count_epoch;
  logic          last_step;
  logic          stage_first;
  logic          epoch_done;

  // scheduler side
  modport master (
    input  start, abort, step_ready, cfg_we, cfg_addr, cfg_data,
           last_stage_idx, stop_epoch,
    output count_step, count_stage, count_epoch, step_valid, last_step,
           stage_first, epoch_done, busy, done
  );

  // datapath / controller side
  modport slave (
    output start, abort, step_ready, cfg_we, cfg_addr, cfg_data,
           last_stage_idx, stop_epoch,
    input  count_step, count_stage, count_epoch, step_valid, last_step,
           stage_first, epoch_done, busy, done
  );
endinterface

// File: rtl/stage_scheduler.sv
// Step -> stage -> epoch sequencer with a programmable per-stage step-limit table.
module stage_scheduler #(
  parameter int NA    = 8,
  parameter int NC    = 4,
  parameter int PowNc = 2**NC,
  parameter int ND    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  stage_scheduler_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state, state_nx;
  logic [PowNc-1:0][NA-1:0]  tbl;
  logic [NA-1:0]             cnt_step;
  logic [NC-1:0]             cnt_stage;
  logic [ND-1:0]             cnt_epoch;
  logic [NC-1:0]             shd_last;
  logic [ND-1:0]             shd_stop;
  logic                      epoch_done_q;
  logic                      busy, step_valid, done;

  logic [NA-1:0] lim;
  logic          fire, end_step, end_stage, end_epoch;

  assign lim       = tbl[cnt_stage];
  assign fire      = step_valid & bus.step_ready;
  assign end_step  = (cnt_step  >= lim);
  assign end_stage = (cnt_stage >= shd_last);
  assign end_epoch = (cnt_epoch >= shd_stop);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state: abort beats a concurrent fire; the last fire of the last epoch ends the run
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.start) state_nx = S_RUN;
      S_RUN: begin
        if (bus.abort)                                     state_nx = S_IDLE;
        else if (fire && end_step && end_stage && end_epoch) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy       = 1'b0;
    step_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_RUN:   begin busy = 1'b1; step_valid = 1'b1; end
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // limit table: writable only while idle, so a run never sees its limits change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             tbl <= '0;
    else if (state == S_IDLE && bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_data;
  end

  // counters and run bounds; counters hold at their final values through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_step  <= '0;
      cnt_stage <= '0;
      cnt_epoch <= '0;
      shd_last  <= '0;
      shd_stop  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start) begin
          cnt_step  <= '0;
          cnt_stage <= '0;
          cnt_epoch <= '0;
          shd_last  <= bus.last_stage_idx;
          shd_stop  <= bus.stop_epoch;
        end
        S_RUN: begin
          if (bus.abort) begin
            cnt_step  <= '0;
            cnt_stage <= '0;
            cnt_epoch <= '0;
          end else if (fire) begin
            if (!end_step) cnt_step <= cnt_step + 1'b1;
            else if (!end_stage) begin
              cnt_step  <= '0;
              cnt_stage <= cnt_stage + 1'b1;
            end else if (!end_epoch) begin
              cnt_step  <= '0;
              cnt_stage <= '0;
              cnt_epoch <= cnt_epoch + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // epoch_done pulses the cycle after the final step of any epoch is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) epoch_done_q <= 1'b0;
    else     epoch_done_q <= (state == S_RUN) && !bus.abort && fire && end_step && end_stage;
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.step_valid  = step_valid;
  assign bus.count_step  = cnt_step;
  assign bus.count_stage = cnt_stage;
  assign bus.count_epoch = cnt_epoch;
  assign bus.epoch_done  = epoch_done_q;
  assign bus.last_step   = step_valid && (cnt_step == lim);
  assign bus.stage_first = step_valid && (cnt_step == '0);

endmodule

// File: tb/tb_stage_scheduler.sv
// Randomized self-checking bench for stage_scheduler against a nested-loop schedule model.
module tb_stage_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  // reference configuration
  int mtbl [16];
  int mlast = 0;
  int mstop = 0;

  typedef struct {int step; int stage; int epoch; bit eoe;} exp_t;

  stage_scheduler_if #(.NA(8), .NC(4), .ND(16)) bus ();

  stage_scheduler #(.NA(8), .NC(4), .PowNc(16), .ND(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(a);
    bus.cfg_data = 8'(d);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    mtbl[a] = d;
  endtask

  // pct<0 toggles ready 1-0-1-0; abort_at = index of the step aborted (with concurrent ready);
  // wr_at = cycle at which an ignored write of table[0]=5 is issued during the run
  task automatic run(input int pct, input int abort_at, input int wr_at);
    exp_t q[$];
    int   idx = 0;
    bit   ped = 0;
    bit   fin = 0;
    bit   tog = 1;
    bit   rdy, ab;
    for (int e = 0; e <= mstop; e++)
      for (int s = 0; s <= mlast; s++)
        for (int t = 0; t <= mtbl[s]; t++)
          q.push_back('{t, s, e, (s == mlast) && (t == mtbl[s])});
    bus.last_stage_idx = 4'(mlast);
    bus.stop_epoch     = 16'(mstop);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    // bounds must have been captured at start
    bus.last_stage_idx = 4'($urandom);
    bus.stop_epoch     = 16'($urandom);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      chk("step_valid", bus.step_valid, 1);
      chk("busy", bus.busy, 1);
      chk("done_early", bus.done, 0);
      chk("epoch_done", bus.epoch_done, ped);
      chk("count_step", bus.count_step, q[idx].step);
      chk("count_stage", bus.count_stage, q[idx].stage);
      chk("count_epoch", bus.count_epoch, q[idx].epoch);
      chk("last_step", bus.last_step, q[idx].step == mtbl[q[idx].stage]);
      chk("stage_first", bus.stage_first, q[idx].step == 0);
      if (pct < 0) begin rdy = tog; tog = !tog; end
      else rdy = ($urandom_range(0, 99) < pct);
      ab = (idx == abort_at);
      if (ab) rdy = 1'b1;
      bus.step_ready = rdy;
      bus.abort      = ab;
      if (cyc == wr_at) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 8'd5;
      end
      @(posedge clk); #1;
      bus.cfg_we = 1'b0; bus.abort = 1'b0; bus.step_ready = 1'b0;
      if (ab) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.step_valid, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_epoch_done", bus.epoch_done, 0);
        chk("abort_step", bus.count_step, 0);
        chk("abort_stage", bus.count_stage, 0);
        chk("abort_epoch", bus.count_epoch, 0);
        fin = 1;
      end else begin
        ped = rdy ? q[idx].eoe : 1'b0;
        if (rdy) idx++;
        if (idx == q.size()) begin
          chk("done", bus.done, 1);
          chk("done_busy", bus.busy, 1);
          chk("done_valid", bus.step_valid, 0);
          chk("final_epoch_done", bus.epoch_done, ped);
          chk("final_step", bus.count_step, q[idx-1].step);
          chk("final_stage", bus.count_stage, q[idx-1].stage);
          chk("final_epoch", bus.count_epoch, q[idx-1].epoch);
          @(posedge clk); #1;
          chk("idle_busy", bus.busy, 0);
          chk("idle_done", bus.done, 0);
          chk("idle_epoch_done", bus.epoch_done, 0);
          fin = 1;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    int a, d;
    foreach (mtbl[i]) mtbl[i] = 0;
    bus.start = 0; bus.abort = 0; bus.step_ready = 0; bus.cfg_we = 0;
    bus.cfg_addr = '0; bus.cfg_data = '0; bus.last_stage_idx = '0; bus.stop_epoch = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.step_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_epoch_done", bus.epoch_done, 0);
    chk("rst_counts", {bus.count_step, bus.count_stage, bus.count_epoch}, 0);

    // untouched table: 16 one-step stages, one epoch
    mlast = 15; mstop = 0;
    run(100, -1, -1);

    // two-stage, two-epoch schedule, full rate then toggled ready
    cfg_write(0, 2); cfg_write(1, 0);
    mlast = 1; mstop = 1;
    run(100, -1, -1);
    run(-1, -1, -1);
    // table write during RUN is dropped
    run(100, -1, 1);
    // same write in IDLE takes effect
    cfg_write(0, 5);
    run(70, -1, -1);
    // abort at epoch 0, stage 1, together with a fire
    cfg_write(0, 2);
    run(100, 3, -1);
    // widest stage: 256 steps
    cfg_write(0, 255);
    mlast = 0; mstop = 0;
    run(100, -1, -1);

    // random configurations, with a table write landing on the start edge
    for (int it = 0; it < 6; it++) begin
      mlast = $urandom_range(0, 3);
      mstop = $urandom_range(0, 2);
      for (int s = 0; s <= mlast; s++) cfg_write(s, $urandom_range(0, 3));
      a = $urandom_range(0, mlast);
      d = $urandom_range(0, 3);
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'(a); bus.cfg_data = 8'(d);
      mtbl[a] = d;
      run($urandom_range(40, 100), -1, -1);
    end

    // reset between edges mid-run
    cfg_write(0, 3); cfg_write(1, 3);
    bus.last_stage_idx = 4'd1; bus.stop_epoch = 16'd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.step_ready = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.step_valid, 0);
    chk("midrst_step", bus.count_step, 0);
    chk("midrst_stage", bus.count_stage, 0);
    chk("midrst_epoch", bus.count_epoch, 0);
    #1 rst = 1'b0;
    bus.step_ready = 1'b0;
    @(posedge clk); #1;
    foreach (mtbl[i]) mtbl[i] = 0;
    mlast = 1; mstop = 0;
    run(100, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_scheduler.md
Name: stage_scheduler

Overview:
- Single-clock, fully synchronous sequencer for the step/stage/epoch iteration of the training datapath.
- Holds a programmable per-stage step-limit table and walks step -> stage -> epoch.
- Presents each step to the datapath with a valid/ready handshake, and reports progress and completion to the top-level controller through start/busy/done.

Parameters:
NA, 8, step counter and step-limit width
NC, 4, stage index width
PowNc, 16, number of step-limit table entries (2**NC)
ND, 16, epoch counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a run; sampled in IDLE only
abort  input  1  terminate a run; sampled in RUN only
step_ready  input  1  datapath accepts the current step
cfg_we  input  1  table write strobe
cfg_addr  input  NC  table write index
cfg_data  input  NA  step limit for entry cfg_addr
last_stage_idx  input  NC  index of the final stage, inclusive
stop_epoch  input  ND  index of the final epoch, inclusive
count_step  output  NA  current step index
count_stage  output  NC  current stage index
count_epoch  output  ND  current epoch index
step_valid  output  1  current step offered to the datapath
last_step  output  1  count_step equals the current stage limit, while step_valid
stage_first  output  1  step_valid with count_step==0
epoch_done  output  1  one-cycle pulse on acceptance of the final step of an epoch
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; all counters 0.
  - step_valid, epoch_done, done and busy are 0.
  - All table entries are 0.
  - Shadow last_stage and shadow stop_epoch are 0.
- Limits are inclusive:
  - Stage s runs table[s]+1 steps.
  - A run covers last_stage_idx+1 stages per epoch and stop_epoch+1 epochs.
- fire = step_valid & step_ready.
- Table writes:
  - Take effect at the clock edge when cfg_we=1 and FSM=IDLE.
  - Ignored in RUN and DONE.
- States:
  - IDLE: busy=0. start=1 -> RUN next cycle; counters cleared; last_stage_idx and stop_epoch latched into shadow registers. cfg_we and start in the same cycle: the write lands and the run uses the new value.
  - RUN: busy=1, step_valid=1. Outputs are registered and visible the cycle after entry. Latency start -> first step_valid is 1 cycle.
  - DONE: busy=1, step_valid=0, done=1 for exactly one cycle -> IDLE.
- On fire in RUN, with lim = table[count_stage]:
  - count_step < lim: count_step+1.
  - Otherwise count_step=0, and:
    - count_stage < shadow last_stage: count_stage+1.
    - Otherwise count_stage=0 and epoch_done=1 next cycle, then:
      - count_epoch < shadow stop_epoch: count_epoch+1.
      - Otherwise -> DONE; counters hold their final values.
- No fire: all counters hold, and step_valid stays asserted (no retraction).
- abort=1 in RUN:
  - -> IDLE next cycle; counters cleared to 0; no done and no epoch_done.
  - abort has priority over a simultaneous fire.
- start is ignored in RUN and DONE. abort is ignored outside RUN.
- Arithmetic and widths:
  - All compares are unsigned at native width; counters never wrap.
  - Limit 255 gives 256 steps; table entry 0 gives a one-step stage.
  - last_stage_idx=15 uses all 16 entries.
  - stop_epoch=0 gives a single epoch.
- Reset asserted mid-run: immediate return to IDLE and the reset values above, including the table.
- last_step and stage_first are combinational from registered state, and are 0 when step_valid=0.

Test Plan:
- Write table[0]=2, table[1]=0; last_stage_idx=1, stop_epoch=1; start; step_ready=1 -> 8 fires, (step,stage) = (0,0),(1,0),(2,0),(0,1) per epoch, epoch 0 then 1; epoch_done pulses twice; done pulses 1 cycle after the 8th fire; busy falls with done.
- Same config, step_ready toggled 1-0-1-0 -> counters hold on ready=0; step_valid stays 1; total fires is still 8.
- cfg_we=1 writing table[0]=5 during RUN -> ignored; the run still uses 2. Repeat the write in IDLE, then run -> stage 0 takes 6 steps.
- Abort at epoch 0, stage 1, concurrent with fire -> no counter advance; next cycle IDLE; counters 0; done never pulses.
- Reset values with no writes; last_stage_idx=15, stop_epoch=0 -> 16 fires, last_step=1 on each fire, stage_first=1 on each, one epoch_done, one done.
- rst asserted mid-run between clock edges -> outputs go to reset values immediately, without a clock edge; a table read after restart returns 0.
